// File: rtl/accu_counter.sv
// Registered up/down accumulator with programmable limit, wrap/saturate modes and boundary flags.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module accu_counter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INC_WIDTH = 8,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    input  logic                 down,
    input  logic                 sat_mode,
    input  logic [INC_WIDTH-1:0] increment,
    input  logic [WIDTH-1:0]     limit,
    output logic [WIDTH-1:0]     count,
    output logic                 wrap,
    output logic                 ovf
);

    // One extra bit so limit = 2^WIDTH-1 plus an increment never loses the carry.
    localparam int unsigned EW = WIDTH + 1;

    if (INC_WIDTH > WIDTH || PRESCALE < 1) begin : g_bad_param
        $error("accu_counter: need INC_WIDTH <= WIDTH and PRESCALE >= 1");
    end

    logic [EW-1:0]    cnt_x;
    logic [EW-1:0]    lim_x;
    logic [EW-1:0]    inc_x;
    logic [EW-1:0]    lim_p1;
    logic [EW-1:0]    sum_x;
    logic [EW-1:0]    dif_x;
    logic [WIDTH-1:0] step_val;
    logic             step_evt;
    logic             step_c;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_cnt;

    assign step_c = en && (pre_cnt == PW'(PRESCALE - 1));

    // Counts enabled cycles; frozen while en is low.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= step_c ? '0 : pre_cnt + PW'(1);
        end
    end
`else
    assign step_c = en;
`endif

    // Next value and boundary event for one step.
    always_comb begin
        cnt_x    = EW'(count);
        lim_x    = EW'(limit);
        inc_x    = EW'(increment);
        lim_p1   = lim_x + EW'(1);
        sum_x    = cnt_x + inc_x;
        dif_x    = cnt_x - inc_x;
        step_val = count;
        step_evt = 1'b0;
        if (inc_x != '0) begin
            if (!sat_mode && inc_x > lim_x) begin
                step_val = '0;
                step_evt = 1'b1;
            end else if (!down) begin
                if (sum_x <= lim_x) begin
                    step_val = WIDTH'(sum_x);
                    step_evt = sat_mode && (sum_x == lim_x);
                end else if (!sat_mode) begin
                    step_val = WIDTH'(sum_x - lim_p1);
                    step_evt = 1'b1;
                end else if (cnt_x != lim_x) begin
                    step_val = limit;
                    step_evt = 1'b1;
                end
            end else begin
                if (inc_x <= cnt_x) begin
                    step_val = (dif_x > lim_x) ? limit : WIDTH'(dif_x);
                    step_evt = sat_mode && (dif_x == '0);
                end else if (!sat_mode) begin
                    step_val = WIDTH'(cnt_x + lim_p1 - inc_x);
                    step_evt = 1'b1;
                end else if (cnt_x != '0) begin
                    step_val = '0;
                    step_evt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= (load_value > limit) ? limit : load_value;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (step_c) begin
            count <= step_val;
            wrap  <= step_evt;
            ovf   <= ovf | step_evt;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accu_counter.sv
// Directed bench for accu_counter: arithmetic reference model checked every cycle plus literal checks.
module tb_accu_counter;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned INC_WIDTH = 8;
    localparam int unsigned PRESCALE  = 4;
`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PRE = PRESCALE;
`else
    localparam int unsigned PRE = 1;
`endif
    localparam longint MASK = 64'h0000_0000_FFFF_FFFF;

    logic                 clk;
    logic                 reset;
    logic                 en;
    logic                 load;
    logic [WIDTH-1:0]     load_value;
    logic                 down;
    logic                 sat_mode;
    logic [INC_WIDTH-1:0] increment;
    logic [WIDTH-1:0]     limit;
    logic [WIDTH-1:0]     count;
    logic                 wrap;
    logic                 ovf;

    int     n_vec = 0;
    int     n_err = 0;
    bit     chk_on = 0;
    longint m_count = 0;
    bit     m_wrap = 0;
    bit     m_ovf = 0;
    int     m_pre = 0;

    accu_counter #(.WIDTH(WIDTH), .INC_WIDTH(INC_WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_value(load_value),
        .down(down), .sat_mode(sat_mode), .increment(increment), .limit(limit),
        .count(count), .wrap(wrap), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: apply the counting rules to plain integers.
    function automatic void model_step(input longint c, input longint lim, input longint inc,
                                       input bit dn, input bit sat,
                                       output longint n, output bit ev);
        longint t;
        n  = c;
        ev = 0;
        if (inc == 0) return;
        if (!sat && inc > lim) begin
            n = 0; ev = 1; return;
        end
        t = dn ? c - inc : c + inc;
        if (!dn) begin
            if (t <= lim)     begin n = t; ev = sat && (t == lim); end
            else if (!sat)    begin n = (t - (lim + 1)) & MASK; ev = 1; end
            else if (c != lim) begin n = lim; ev = 1; end
        end else begin
            if (t >= 0)       begin n = (t > lim) ? lim : t; ev = sat && (t == 0); end
            else if (!sat)    begin n = t + lim + 1; ev = 1; end
            else if (c != 0)  begin n = 0; ev = 1; end
        end
    endfunction

    always @(posedge clk) begin
        longint n;
        bit     ev;
        if (reset) begin
            m_count = 0; m_wrap = 0; m_ovf = 0; m_pre = 0;
        end else if (load) begin
            m_count = (longint'(load_value) > longint'(limit)) ? longint'(limit) : longint'(load_value);
            m_wrap = 0; m_ovf = 0; m_pre = 0;
        end else if (en) begin
            if (m_pre == int'(PRE) - 1) begin
                m_pre = 0;
                model_step(m_count, longint'(limit), longint'(increment), down, sat_mode, n, ev);
                m_count = n;
                m_wrap  = ev;
                m_ovf   = m_ovf | ev;
            end else begin
                m_pre++;
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("count", 64'(count), 64'(m_count));
            check("wrap", 64'(wrap), 64'(m_wrap));
            check("ovf", 64'(ovf), 64'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Enough enabled edges for exactly one step regardless of prescaling.
    task automatic tick_step();
        for (int k = 0; k < int'(PRE); k++) tick();
    endtask

    task automatic lit(input string nm, input longint c, input bit w, input bit o);
        check({nm, "_count"}, 64'(count), 64'(c));
        check({nm, "_wrap"}, 64'(wrap), 64'(w));
        check({nm, "_ovf"}, 64'(ovf), 64'(o));
        check({nm, "_model"}, 64'(m_count), 64'(c));
    endtask

    task automatic do_load(input longint v);
        load = 1; load_value = WIDTH'(v); en = 0;
        tick();
        load = 0;
    endtask

    initial begin
        reset = 1; en = 1; load = 0; load_value = '0; down = 0; sat_mode = 0;
        increment = 8'd5; limit = '1;
        tick();
        chk_on = 1;
        lit("reset0", 0, 0, 0);
        tick(); lit("reset1", 0, 0, 0);
        tick(); lit("reset2", 0, 0, 0);
        reset = 0;
        tick_step(); lit("post_reset", 5, 0, 0);

        // Up wrap
        limit = 9; sat_mode = 0; down = 0;
        do_load(7); lit("load7", 7, 0, 0);
        en = 1; increment = 8'd4;
        tick_step(); lit("up_wrap", 1, 1, 1);
        en = 0;
        tick(); lit("up_wrap_after", 1, 0, 1);

        // Down saturate
        limit = 100; sat_mode = 1; down = 1;
        do_load(3);
        en = 1; increment = 8'd5;
        tick_step(); lit("dn_sat", 0, 1, 1);
        tick_step(); lit("dn_sat_hold", 0, 0, 1);

        // Full-range wrap
        limit = 32'hFFFF_FFFF; sat_mode = 0; down = 0;
        do_load(64'hFFFF_FFFE);
        en = 1; increment = 8'd3;
        tick_step(); lit("full_wrap", 1, 1, 1);

        // Load priority and clamp, then reset over load
        limit = 20; load = 1; en = 1; load_value = 50;
        tick(); lit("load_clamp", 20, 0, 0);
        reset = 1;
        tick(); lit("reset_load", 0, 0, 0);
        reset = 0; load = 0; en = 0;

        // Saturating step landing exactly on limit, then saturated hold
        limit = 10; sat_mode = 1; down = 0;
        do_load(6);
        en = 1; increment = 8'd4;
        tick_step(); lit("sat_hit", 10, 1, 1);
        tick_step(); lit("sat_hold", 10, 0, 1);

        // Oversize increment in wrap mode, and zero increment
        limit = 3; sat_mode = 0;
        do_load(2);
        en = 1; increment = 8'd5;
        tick_step(); lit("oversize", 0, 1, 1);
        increment = 8'd0;
        tick_step(); lit("zero_inc", 0, 0, 1);

        // Limit lowered below count: down step clamps, up step crosses
        limit = 100; do_load(50);
        limit = 20; down = 1; en = 1; increment = 8'd5;
        tick_step(); lit("dn_clamp", 20, 0, 0);
        limit = 100; do_load(50);
        limit = 20; down = 0; sat_mode = 1; en = 1; increment = 8'd1;
        tick_step(); lit("up_over", 20, 1, 1);

        // Mixed stimulus checked by the model only
        for (int k = 0; k < 80; k++) begin
            limit      = WIDTH'($urandom_range(15, 0));
            increment  = INC_WIDTH'($urandom_range(20, 0));
            down       = 1'($urandom_range(1, 0));
            sat_mode   = 1'($urandom_range(1, 0));
            en         = ($urandom_range(3, 0) != 0);
            load       = ($urandom_range(9, 0) == 0);
            load_value = WIDTH'($urandom_range(20, 0));
            reset      = ($urandom_range(39, 0) == 0);
            tick();
        end
        reset = 0; load = 0; en = 0;

`ifdef COUNTER_PRESCALE_EN
        reset = 1; tick(); reset = 0;
        limit = 1000; increment = 8'd1; down = 0; sat_mode = 0; en = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("pre_count", 64'(count), 64'(k / 4));
        end
        tick(); lit("pre_mid", 3, 0, 0);
        en = 0; tick(); tick(); lit("pre_idle", 3, 0, 0);
        en = 1; tick(); tick(); lit("pre_resume", 3, 0, 0);
        tick(); lit("pre_fire", 4, 0, 0);
        en = 0;
`endif

        tick();
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
